sad_motion_search: RTL and testbench
====================================

SAD_MOTION_SEARCH -- requirements
Module: sad_motion_search

Interface
REQ-001 SHALL have parameter PIX_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter BLK, default 16: reference block edge in pixels, power of 2, at least 4.
REQ-003 SHALL have parameter RANGE, default 8: search range, power of 2; dx and dy each span -RANGE..RANGE-1.
REQ-004 SHALL have parameter EARLY_TERM, default 0: 1 enables early candidate abort.
REQ-005 SHALL derive SW = BLK+2*RANGE (window edge), SAD_W = PIX_W+2*log2(BLK), MV_W = log2(RANGE)+1, NC = (2*RANGE)^2.
REQ-006 SHALL have port clock, input, 1: the only clock; all state on rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: search request, sampled only in IDLE.
REQ-009 SHALL have port ref_addr, output, 2*log2(BLK): reference pixel address, row*BLK+col.
REQ-010 SHALL have port srch_addr, output, ceil(log2(SW*SW)): window pixel address, y*SW+x.
REQ-011 SHALL have port rd_en, output, 1: read strobe for both memories.
REQ-012 SHALL have port ref_data, input, PIX_W: reference pixel, valid one cycle after its rd_en.
REQ-013 SHALL have port srch_data, input, PIX_W: window pixel, valid one cycle after its rd_en.
REQ-014 SHALL have port busy, output, 1: high from the accepting edge until done.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port best_sad, output, SAD_W: minimum SAD found, unsigned.
REQ-017 SHALL have port best_mvx, output, MV_W: best dx, two's complement.
REQ-018 SHALL have port best_mvy, output, MV_W: best dy, two's complement.

Function
REQ-019 SHALL use FSM states IDLE, RUN, FLUSH, DONE.
REQ-020 SHALL move IDLE->RUN on start=1, setting busy=1, best_sad=all-ones, best_mvx=best_mvy=0.
REQ-021 SHALL stay in RUN for one pixel pair per cycle with rd_en=1, visiting candidates dy-major then dx (dy,dx from -RANGE upward) and pixels row-major within each candidate.
REQ-022 SHALL drive, for candidate (dx,dy) and pixel (r,c): ref_addr=r*BLK+c and srch_addr=(r+dy+RANGE)*SW+(c+dx+RANGE).
REQ-023 SHALL accumulate |ref_data-srch_data| as an unsigned difference into a SAD_W-bit accumulator, with no saturation or overflow possible.
REQ-024 SHALL reload the accumulator with the difference, not add to it, for pixel (0,0) of each candidate.
REQ-025 SHALL compare a candidate's complete SAD the cycle after its last data arrives, and update best_sad/mv only if SAD < best_sad strictly, so ties keep the earliest candidate in scan order.
REQ-026 SHALL, after issuing the last pixel of the last candidate, go RUN->FLUSH (rd_en=0) until the final compare is done, then go to DONE.
REQ-027 SHALL, in DONE, assert done=1 for one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-028 SHALL, with EARLY_TERM=0, assert done exactly NC*BLK*BLK+2 cycles after the start-accepting edge.
REQ-029 SHALL, with EARLY_TERM=1, abort a candidate other than the first once the registered partial SAD >= best_sad: the next issued address is pixel (0,0) of the next candidate, the in-flight read is discarded, and the aborted candidate never updates best.
REQ-030 SHALL, with EARLY_TERM=1, abort on the last candidate by going to FLUSH immediately.
REQ-031 SHALL, with EARLY_TERM=1, give the same best_sad/mv as EARLY_TERM=0 for every input.
REQ-032 SHALL ignore start while busy=1, and a start held high across DONE SHALL start a new search on the following IDLE cycle.
REQ-033 SHALL hold best_sad/mv stable from done until the next accepted start.
REQ-034 SHALL keep rd_en=0 and addresses at their last value in IDLE, FLUSH and DONE.

Reset
REQ-035 SHALL, while reset_n=0, immediately force FSM=IDLE, busy=0, done=0, rd_en=0, ref_addr=0, srch_addr=0, best_sad=all-ones, best_mvx=0, best_mvy=0, and clear the accumulator and counters.
REQ-036 SHALL, on reset mid-search, abandon the search with no done pulse, and SHALL accept start on the first edge after reset_n rises.

Verification (defaults: BLK=16, RANGE=8, SW=32)
REQ-037 SHALL test exact match: the reference block is embedded at dx=3, dy=-2 and the other window pixels differ by at least 1 -> best_sad=0, mv=(3,-2), done at cycle 65538.
REQ-038 SHALL test all ties: ref all 10, window all 12 -> best_sad=512, mv=(-8,-8).
REQ-039 SHALL test maximum SAD: ref all 255, window all 0 -> best_sad=65280, mv=(-8,-8), with no wrap.
REQ-040 SHALL test a start pulse at cycle 100 of a search -> it is ignored, a single done at 65538, and results match the isolated run.
REQ-041 SHALL test reset_n low at cycle 1000 -> all outputs take reset values asynchronously with no done, and a following search gives correct results.
REQ-042 SHALL test EARLY_TERM=1 on the REQ-037 data -> identical results, done strictly before cycle 65538, and no srch_addr outside 0..1023.

Source files
------------

// File: rtl/sad_motion_search.sv
// Full-search block motion estimator: streams one reference/window pixel pair per cycle,
// accumulates the SAD of every candidate and keeps the earliest minimum in scan order.
module sad_motion_search #(
    parameter int PIX_W      = 8,
    parameter int BLK        = 16,
    parameter int RANGE      = 8,
    parameter int EARLY_TERM = 0,
    localparam int LB        = $clog2(BLK),
    localparam int SW        = BLK + 2 * RANGE,
    localparam int SAD_W     = PIX_W + 2 * LB,
    localparam int MV_W      = $clog2(RANGE) + 1,
    localparam int SA_W      = $clog2(SW * SW)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [2*LB-1:0]   ref_addr,
    output logic [SA_W-1:0]   srch_addr,
    output logic              rd_en,
    input  logic [PIX_W-1:0]  ref_data,
    input  logic [PIX_W-1:0]  srch_data,
    output logic              busy,
    output logic              done,
    output logic [SAD_W-1:0]  best_sad,
    output logic [MV_W-1:0]   best_mvx,
    output logic [MV_W-1:0]   best_mvy
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    localparam int              NC      = (2 * RANGE) * (2 * RANGE);
    localparam logic            ET      = (EARLY_TERM != 0);
    localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

    state_t            state_r, state_s;
    logic [LB-1:0]     col_r, row_r, col_s, row_s;
    logic [MV_W-1:0]   cx_r, cy_r, cx_s, cy_s;
    logic              pix_last_s, cand_last_s, issue_end_s, abort_s, final_cmp_s;
    logic [SA_W-1:0]   srch_n_s;
    logic [PIX_W-1:0]  diff_s;

    // Stage 1 tracks the read in flight, stage 2 the pixel already folded into acc_r.
    logic              p1_valid_r, p1_first_r, p1_last_r;
    logic [MV_W-1:0]   p1_cx_r, p1_cy_r;
    logic              p2_valid_r, p2_last_r;
    logic [MV_W-1:0]   p2_cx_r, p2_cy_r;
    logic [SAD_W-1:0]  acc_r;

    // Scan position successor, early-abort decision and next window address.
    always_comb begin
        pix_last_s  = (row_r == LB'(BLK - 1)) && (col_r == LB'(BLK - 1));
        cand_last_s = ({cy_r, cx_r} == (2 * MV_W)'(NC - 1));
        abort_s     = 1'b0;
        if (ET && (state_r == RUN) && p2_valid_r && (p2_cx_r == cx_r) && (p2_cy_r == cy_r)
            && ({cy_r, cx_r} != {(2 * MV_W){1'b0}}) && (acc_r >= best_sad)) begin
            abort_s = 1'b1;
        end else begin
            abort_s = 1'b0;
        end
        issue_end_s = (pix_last_s || abort_s) && cand_last_s;
        final_cmp_s = p2_valid_r && p2_last_r;
        col_s = col_r;
        row_s = row_r;
        cx_s  = cx_r;
        cy_s  = cy_r;
        if (pix_last_s || abort_s) begin
            col_s = {LB{1'b0}};
            row_s = {LB{1'b0}};
            if (cx_r == MV_W'(2 * RANGE - 1)) begin
                cx_s = {MV_W{1'b0}};
                cy_s = cy_r + 1'b1;
            end else begin
                cx_s = cx_r + 1'b1;
            end
        end else if (col_r == LB'(BLK - 1)) begin
            col_s = {LB{1'b0}};
            row_s = row_r + 1'b1;
        end else begin
            col_s = col_r + 1'b1;
        end
        srch_n_s = (SA_W'(row_s) + SA_W'(cy_s)) * SA_W'(SW) + SA_W'(col_s) + SA_W'(cx_s);
        diff_s   = (ref_data >= srch_data) ? (ref_data - srch_data) : (srch_data - ref_data);
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start) state_s = RUN; else state_s = IDLE;
            RUN:     if (issue_end_s) state_s = FLUSH; else state_s = RUN;
            FLUSH:   if (final_cmp_s || (!p1_valid_r && !p2_valid_r)) state_s = DONE;
                     else state_s = FLUSH;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= state_s;
    end

    // Address generation, SAD pipeline, best tracking and status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_r      <= {LB{1'b0}};
            row_r      <= {LB{1'b0}};
            cx_r       <= {MV_W{1'b0}};
            cy_r       <= {MV_W{1'b0}};
            ref_addr   <= {(2 * LB){1'b0}};
            srch_addr  <= {SA_W{1'b0}};
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            best_sad   <= SAD_MAX;
            best_mvx   <= {MV_W{1'b0}};
            best_mvy   <= {MV_W{1'b0}};
            p1_valid_r <= 1'b0;
            p1_first_r <= 1'b0;
            p1_last_r  <= 1'b0;
            p1_cx_r    <= {MV_W{1'b0}};
            p1_cy_r    <= {MV_W{1'b0}};
            p2_valid_r <= 1'b0;
            p2_last_r  <= 1'b0;
            p2_cx_r    <= {MV_W{1'b0}};
            p2_cy_r    <= {MV_W{1'b0}};
            acc_r      <= {SAD_W{1'b0}};
        end else begin
            // An abort drops both the read being captured and the data arriving now.
            p1_valid_r <= rd_en && !abort_s;
            p1_first_r <= (row_r == {LB{1'b0}}) && (col_r == {LB{1'b0}});
            p1_last_r  <= pix_last_s;
            p1_cx_r    <= cx_r;
            p1_cy_r    <= cy_r;
            p2_valid_r <= p1_valid_r && !abort_s;
            p2_last_r  <= p1_last_r;
            p2_cx_r    <= p1_cx_r;
            p2_cy_r    <= p1_cy_r;
            if (p1_valid_r && !abort_s) begin
                acc_r <= p1_first_r ? SAD_W'(diff_s) : (acc_r + SAD_W'(diff_s));
            end
            if (final_cmp_s && (acc_r < best_sad)) begin
                best_sad <= acc_r;
                best_mvx <= p2_cx_r - MV_W'(RANGE);
                best_mvy <= p2_cy_r - MV_W'(RANGE);
            end
            case (state_r)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    rd_en     <= 1'b1;
                    col_r     <= {LB{1'b0}};
                    row_r     <= {LB{1'b0}};
                    cx_r      <= {MV_W{1'b0}};
                    cy_r      <= {MV_W{1'b0}};
                    ref_addr  <= {(2 * LB){1'b0}};
                    srch_addr <= {SA_W{1'b0}};
                    best_sad  <= SAD_MAX;
                    best_mvx  <= {MV_W{1'b0}};
                    best_mvy  <= {MV_W{1'b0}};
                end
                RUN: if (issue_end_s) begin
                    rd_en <= 1'b0;
                end else begin
                    col_r     <= col_s;
                    row_r     <= row_s;
                    cx_r      <= cx_s;
                    cy_r      <= cy_s;
                    ref_addr  <= {row_s, col_s};
                    srch_addr <= srch_n_s;
                end
                FLUSH: if (state_s == DONE) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                DONE:    done <= 1'b0;
                default: done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_motion_search.sv
// Directed bench for sad_motion_search with BLK=4, RANGE=2 (SW=8, 16 candidates, done at 258);
// one instance without and one with early termination share the same pixel memories.
module tb_sad_motion_search;

    localparam int BLK = 4, RANGE = 2, SW = 8, NPIX = 16, NCAND = 16;
    localparam int LAT = NCAND * NPIX + 2;
    localparam int MAXCYC = 300;

    logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
    always #5 clock = ~clock;

    logic [7:0]  ref_mem [16];
    logic [7:0]  win_mem [64];

    logic [3:0]  ref_addr_0, ref_addr_1;
    logic [5:0]  srch_addr_0, srch_addr_1;
    logic        rd_en_0, rd_en_1, busy_0, busy_1, done_0, done_1;
    logic [7:0]  ref_data_0, srch_data_0, ref_data_1, srch_data_1;
    logic [11:0] best_sad_0, best_sad_1;
    logic [1:0]  best_mvx_0, best_mvy_0, best_mvx_1, best_mvy_1;

    int checks = 0, errors = 0;
    int issue_cnt = 0, addr_err = 0, range_err = 0;
    int lat0, lat1, nd0, nd1;

    sad_motion_search #(.PIX_W(8), .BLK(BLK), .RANGE(RANGE), .EARLY_TERM(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start), .ref_addr(ref_addr_0),
        .srch_addr(srch_addr_0), .rd_en(rd_en_0), .ref_data(ref_data_0), .srch_data(srch_data_0),
        .busy(busy_0), .done(done_0), .best_sad(best_sad_0), .best_mvx(best_mvx_0),
        .best_mvy(best_mvy_0));

    sad_motion_search #(.PIX_W(8), .BLK(BLK), .RANGE(RANGE), .EARLY_TERM(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .ref_addr(ref_addr_1),
        .srch_addr(srch_addr_1), .rd_en(rd_en_1), .ref_data(ref_data_1), .srch_data(srch_data_1),
        .busy(busy_1), .done(done_1), .best_sad(best_sad_1), .best_mvx(best_mvx_1),
        .best_mvy(best_mvy_1));

    // Expected window address of the k-th issued pair in dy-major, dx, row-major order.
    function automatic int exp_srch(input int k);
        int cand, pix;
        cand = k / NPIX;
        pix  = k % NPIX;
        return ((pix / BLK) + cand / (2 * RANGE)) * SW + (pix % BLK) + cand % (2 * RANGE);
    endfunction

    // Synchronous memories plus address-sequence tracking.
    always @(posedge clock) begin
        if (rd_en_0) begin
            ref_data_0  <= ref_mem[ref_addr_0];
            srch_data_0 <= win_mem[srch_addr_0];
            if (int'(ref_addr_0) != issue_cnt % NPIX || int'(srch_addr_0) != exp_srch(issue_cnt))
                addr_err <= addr_err + 1;
            issue_cnt <= issue_cnt + 1;
        end
        if (rd_en_1) begin
            ref_data_1  <= ref_mem[ref_addr_1];
            srch_data_1 <= win_mem[srch_addr_1];
            if (int'(srch_addr_1) > (BLK + 2 * RANGE - 2) * (SW + 1))
                range_err <= range_err + 1;
        end
    end

    task automatic fill(input logic [7:0] rv, input logic [7:0] wv);
        for (int i = 0; i < 16; i++) ref_mem[i] = rv;
        for (int i = 0; i < 64; i++) win_mem[i] = wv;
    endtask

    // Distinct reference pixels embedded at dx=1, dy=-1 on a background of 100.
    task automatic load_exact();
        fill(8'd0, 8'd100);
        for (int r = 0; r < BLK; r++)
            for (int c = 0; c < BLK; c++) begin
                ref_mem[r * BLK + c]         = 8'(10 + r * BLK + c);
                win_mem[(r + 1) * SW + c + 3] = 8'(10 + r * BLK + c);
            end
    endtask

    task automatic do_start();
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_done(input int pulse_at, output int l0, output int l1,
                             output int n0, output int n1);
        l0 = -1; l1 = -1; n0 = 0; n1 = 0;
        for (int n = 1; n <= MAXCYC; n++) begin
            @(posedge clock); #1;
            if (done_0) begin n0++; if (l0 < 0) l0 = n; end
            if (done_1) begin n1++; if (l1 < 0) l1 = n; end
            start = (n == pulse_at);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++; if ({busy_0, done_0, rd_en_0} !== 3'b000) begin errors++;
            $display("FAIL rst_ctrl got %b expected 000", {busy_0, done_0, rd_en_0}); end
        checks++; if (ref_addr_0 !== 4'd0 || srch_addr_0 !== 6'd0) begin errors++;
            $display("FAIL rst_addr got %0d/%0d expected 0/0", ref_addr_0, srch_addr_0); end
        checks++; if (best_sad_0 !== 12'hFFF) begin errors++;
            $display("FAIL rst_sad got %0d expected 4095", best_sad_0); end
        checks++; if ({best_mvx_0, best_mvy_0} !== 4'b0000) begin errors++;
            $display("FAIL rst_mv got %b expected 0000", {best_mvx_0, best_mvy_0}); end
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic test_exact_match();
        load_exact();
        @(negedge clock); issue_cnt = 0; addr_err = 0; range_err = 0;
        do_start();
        wait_done(0, lat0, lat1, nd0, nd1);
        checks++; if (lat0 != LAT || nd0 != 1) begin errors++;
            $display("FAIL exact_lat got %0d (%0d pulses) expected %0d (1)", lat0, nd0, LAT); end
        checks++; if (best_sad_0 !== 12'd0) begin errors++;
            $display("FAIL exact_sad got %0d expected 0", best_sad_0); end
        checks++; if (best_mvx_0 !== 2'b01 || best_mvy_0 !== 2'b11) begin errors++;
            $display("FAIL exact_mv got %b,%b expected 01,11", best_mvx_0, best_mvy_0); end
        checks++; if (issue_cnt != NCAND * NPIX || addr_err != 0) begin errors++;
            $display("FAIL addr_seq got %0d issued %0d bad expected %0d issued 0 bad",
                     issue_cnt, addr_err, NCAND * NPIX); end
        checks++; if (best_sad_1 !== 12'd0 || best_mvx_1 !== 2'b01 || best_mvy_1 !== 2'b11) begin
            errors++; $display("FAIL et_result got %0d (%b,%b) expected 0 (01,11)",
                               best_sad_1, best_mvx_1, best_mvy_1); end
        checks++; if (!(lat1 > 0 && lat1 < LAT) || nd1 != 1) begin errors++;
            $display("FAIL et_lat got %0d (%0d pulses) expected below %0d", lat1, nd1, LAT); end
        checks++; if (range_err != 0) begin errors++;
            $display("FAIL et_range got %0d out-of-window reads expected 0", range_err); end
    endtask

    task automatic test_all_ties();
        fill(8'd10, 8'd12);
        do_start();
        wait_done(0, lat0, lat1, nd0, nd1);
        checks++; if (best_sad_0 !== 12'd32 || {best_mvx_0, best_mvy_0} !== 4'b1010) begin errors++;
            $display("FAIL ties got %0d (%b) expected 32 (1010)", best_sad_0, {best_mvx_0, best_mvy_0}); end
        checks++; if (best_sad_1 !== 12'd32 || {best_mvx_1, best_mvy_1} !== 4'b1010) begin errors++;
            $display("FAIL et_ties got %0d (%b) expected 32 (1010)", best_sad_1, {best_mvx_1, best_mvy_1}); end
    endtask

    task automatic test_max_sad();
        fill(8'd255, 8'd0);
        do_start();
        wait_done(0, lat0, lat1, nd0, nd1);
        checks++; if (best_sad_0 !== 12'd4080 || {best_mvx_0, best_mvy_0} !== 4'b1010) begin errors++;
            $display("FAIL max_sad got %0d (%b) expected 4080 (1010)", best_sad_0, {best_mvx_0, best_mvy_0}); end
        checks++; if (best_sad_1 !== 12'd4080) begin errors++;
            $display("FAIL et_max_sad got %0d expected 4080", best_sad_1); end
        checks++; if (lat0 != LAT) begin errors++;
            $display("FAIL max_lat got %0d expected %0d", lat0, LAT); end
        repeat (5) @(posedge clock);
        #1;
        checks++; if (best_sad_0 !== 12'd4080 || busy_0 !== 1'b0) begin errors++;
            $display("FAIL hold got %0d busy %b expected 4080 busy 0", best_sad_0, busy_0); end
    endtask

    task automatic test_start_ignored();
        load_exact();
        do_start();
        wait_done(100, lat0, lat1, nd0, nd1);
        checks++; if (lat0 != LAT || nd0 != 1 || nd1 != 1) begin errors++;
            $display("FAIL ign_start got lat %0d pulses %0d/%0d expected %0d 1/1", lat0, nd0, nd1, LAT); end
        checks++; if (best_sad_0 !== 12'd0 || {best_mvx_0, best_mvy_0} !== 4'b0111) begin errors++;
            $display("FAIL ign_result got %0d (%b) expected 0 (0111)", best_sad_0, {best_mvx_0, best_mvy_0}); end
    endtask

    task automatic test_reset_mid_search();
        load_exact();
        do_start();
        repeat (100) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({busy_0, done_0, rd_en_0, busy_1} !== 4'b0000) begin errors++;
            $display("FAIL midrst_ctrl got %b expected 0000", {busy_0, done_0, rd_en_0, busy_1}); end
        checks++; if (ref_addr_0 !== 4'd0 || srch_addr_0 !== 6'd0 || best_sad_0 !== 12'hFFF
                      || {best_mvx_0, best_mvy_0} !== 4'b0000) begin errors++;
            $display("FAIL midrst_out got %0d/%0d/%0d expected 0/0/4095", ref_addr_0, srch_addr_0, best_sad_0); end
        @(negedge clock);
        @(negedge clock); reset_n = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        checks++; if (busy_0 !== 1'b1 || busy_1 !== 1'b1) begin errors++;
            $display("FAIL midrst_accept got %b%b expected 11", busy_0, busy_1); end
        @(negedge clock); start = 1'b0;
        wait_done(0, lat0, lat1, nd0, nd1);
        checks++; if (lat0 != LAT || best_sad_0 !== 12'd0 || {best_mvx_0, best_mvy_0} !== 4'b0111) begin
            errors++; $display("FAIL midrst_rerun got lat %0d sad %0d expected %0d sad 0", lat0, best_sad_0, LAT); end
    endtask

    task automatic test_back_to_back();
        int n;
        fill(8'd10, 8'd12);
        do_start();
        n = 0;
        while (done_0 !== 1'b1 && n < MAXCYC) begin
            @(posedge clock); #1; n++;
        end
        checks++; if (done_0 !== 1'b1) begin errors++;
            $display("FAIL b2b_first got no done within %0d expected done", MAXCYC); end
        start = 1'b1;
        @(posedge clock); #1;
        checks++; if (busy_0 !== 1'b0 || done_0 !== 1'b0 || best_sad_0 !== 12'd32) begin errors++;
            $display("FAIL b2b_idle got busy %b done %b sad %0d expected 0 0 32", busy_0, done_0, best_sad_0); end
        @(posedge clock); #1;
        checks++; if (busy_0 !== 1'b1) begin errors++;
            $display("FAIL b2b_accept got busy %b expected 1", busy_0); end
        start = 1'b0;
        wait_done(0, lat0, lat1, nd0, nd1);
        checks++; if (lat0 != LAT || best_sad_0 !== 12'd32) begin errors++;
            $display("FAIL b2b_second got lat %0d sad %0d expected %0d 32", lat0, best_sad_0, LAT); end
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_all_ties();
        test_max_sad();
        test_start_ignored();
        test_reset_mid_search();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
